// File: rtl/rst_seq.sv
// Lock-aware reset sequencer: synchronises PLL lock, waits a settle time, then
// releases N_CH reset channels in order. Optional feature macro: RST_SEQ_LOSS_CNT_EN.
module rst_seq #(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pll_locked,
    output logic [N_CH-1:0] rst_out,
`ifdef RST_SEQ_LOSS_CNT_EN
    output logic [7:0]      lock_loss_cnt,
`endif
    output logic            ready
);

    localparam int REL_LAST = STAGGER * (N_CH - 1);
    localparam int CNT_MAX  = (HOLD_CYCLES > REL_LAST) ? HOLD_CYCLES : REL_LAST;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [N_CH-1:0]        r_rst_out;
    logic                   r_ready;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0]             r_loss_cnt;
`endif

    // NOTE: state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
`ifdef RST_SEQ_LOSS_CNT_EN
            r_loss_cnt <= '0;
`endif
        end else if (!w_lock_s && (r_state != WAIT_LOCK)) begin
            // Lock loss overrides any release scheduled for this edge.
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
`ifdef RST_SEQ_LOSS_CNT_EN
            if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
`endif
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (r_cnt == CNT_W'(STAGGER * i)) r_rst_out[i] <= 1'b0;
                    end
                    if (r_cnt == CNT_W'(REL_LAST)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    r_rst_out <= '0;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state   <= WAIT_LOCK;
                    r_rst_out <= '1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;
`ifdef RST_SEQ_LOSS_CNT_EN
    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: randomized lock/reset stimulus compared
// against an edge-count reference model, plus directed latency scenarios.
module tb_rst_seq;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int STG  = 8;
    localparam int SS   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pll = 1'b0;
    logic [N-1:0] rst_out;
    logic         ready;
    logic         rst2 = 1'b1;
    logic         pll2 = 1'b0;
    logic [2:0]   rst_out2;
    logic         ready2;
`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0]   lock_loss_cnt;
    logic [7:0]   lock_loss_cnt2;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rst_seq #(.N_CH(N), .HOLD_CYCLES(HOLD), .STAGGER(STG), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .pll_locked(pll), .rst_out(rst_out),
`ifdef RST_SEQ_LOSS_CNT_EN
        .lock_loss_cnt(lock_loss_cnt),
`endif
        .ready(ready)
    );

    rst_seq #(.N_CH(3), .HOLD_CYCLES(1), .STAGGER(0), .SYNC_STAGES(2)) dut_fast (
        .clk(clk), .rst(rst2), .pll_locked(pll2), .rst_out(rst_out2),
`ifdef RST_SEQ_LOSS_CNT_EN
        .lock_loss_cnt(lock_loss_cnt2),
`endif
        .ready(ready2)
    );

    // Reference model: m_t counts consecutive edges on which the sequencer saw
    // synchronised lock; channel i is released once m_t reaches HOLD+2+STG*i.
    logic [SS-1:0] m_sync = '0;
    int            m_t    = 0;
    int            m_loss = 0;

    always @(posedge clk) begin : model
        bit seen;
        if (rst) begin
            m_sync = '0;
            m_t    = 0;
            m_loss = 0;
        end else begin
            seen   = m_sync[SS-1];
            m_sync = {m_sync[SS-2:0], pll};
            if (seen) begin
                if (m_t < 1000000) m_t++;
            end else begin
                if (m_t > 0 && m_loss < 255) m_loss++;
                m_t = 0;
            end
        end
    end

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_t < HOLD + 2 + STG * i);
        return v;
    endfunction

    function automatic logic exp_ready();
        return (m_t >= HOLD + 2 + STG * (N - 1));
    endfunction

    task automatic step(input logic r, input logic p);
        rst = r;
        pll = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        n_chk++;
        if (rst_out !== 4'b1111 || ready !== 1'b0)
            $display("FAIL reset: rst_out=%b ready=%b expected 1111 0", rst_out, ready);
        else n_pass++;
`ifdef RST_SEQ_LOSS_CNT_EN
        n_chk++;
        if (lock_loss_cnt !== 8'd0)
            $display("FAIL reset_cnt: lock_loss_cnt=%0d expected 0", lock_loss_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_powerup();
        int e0 = 0;
        int er = 0;
        for (int e = 1; e <= 50; e++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (rst_out !== exp_rst() || ready !== exp_ready())
                $display("FAIL powerup edge %0d: rst_out=%b ready=%b expected %b %b",
                         e, rst_out, ready, exp_rst(), exp_ready());
            else n_pass++;
            if (e0 == 0 && rst_out[0] === 1'b0) e0 = e;
            if (er == 0 && ready === 1'b1) er = e;
        end
        n_chk++;
        if (e0 != 20) $display("FAIL powerup_ch0_edge: got %0d expected 20", e0);
        else n_pass++;
        n_chk++;
        if (er != 44) $display("FAIL powerup_ready_edge: got %0d expected 44", er);
        else n_pass++;
    endtask

    task automatic test_lock_loss_run();
        for (int e = 1; e <= 3; e++) begin
            step(1'b0, 1'b0);
            n_chk++;
            if (rst_out !== exp_rst() || ready !== exp_ready())
                $display("FAIL loss_run edge %0d: rst_out=%b ready=%b expected %b %b",
                         e, rst_out, ready, exp_rst(), exp_ready());
            else n_pass++;
        end
        n_chk++;
        if (rst_out !== 4'b1111 || ready !== 1'b0)
            $display("FAIL loss_run_third: rst_out=%b ready=%b expected 1111 0", rst_out, ready);
        else n_pass++;
`ifdef RST_SEQ_LOSS_CNT_EN
        n_chk++;
        if (lock_loss_cnt !== 8'd1)
            $display("FAIL loss_run_cnt: lock_loss_cnt=%0d expected 1", lock_loss_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_loss_mid_release();
        int  er   = 0;
        bit  done = 0;
        for (int e = 1; e <= 100 && !done; e++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (rst_out !== exp_rst())
                $display("FAIL mid_rel_ramp edge %0d: rst_out=%b expected %b", e, rst_out, exp_rst());
            else n_pass++;
            if (exp_rst() == 4'b1100) done = 1;
        end
        n_chk++;
        if (!done) $display("FAIL mid_rel_reach: rst_out=%b expected 1100", rst_out);
        else n_pass++;
        for (int e = 1; e <= 3; e++) begin
            step(1'b0, 1'b0);
            n_chk++;
            if (rst_out !== exp_rst() || ready !== exp_ready())
                $display("FAIL mid_rel_drop edge %0d: rst_out=%b ready=%b expected %b %b",
                         e, rst_out, ready, exp_rst(), exp_ready());
            else n_pass++;
        end
        n_chk++;
        if (rst_out !== 4'b1111)
            $display("FAIL mid_rel_third: rst_out=%b expected 1111", rst_out);
        else n_pass++;
        for (int e = 1; e <= 100 && er == 0; e++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (rst_out !== exp_rst() || ready !== exp_ready())
                $display("FAIL relock edge %0d: rst_out=%b ready=%b expected %b %b",
                         e, rst_out, ready, exp_rst(), exp_ready());
            else n_pass++;
            if (ready === 1'b1) er = e;
        end
        n_chk++;
        if (er != 44) $display("FAIL relock_ready_edge: got %0d expected 44", er);
        else n_pass++;
    endtask

    task automatic test_rst_in_hold();
        int e0 = 0;
        int er = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int e = 1; e <= 9; e++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        n_chk++;
        if (rst_out !== 4'b1111 || ready !== 1'b0)
            $display("FAIL rst_hold_apply: rst_out=%b ready=%b expected 1111 0", rst_out, ready);
        else n_pass++;
        for (int e = 1; e <= 100 && er == 0; e++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (rst_out !== exp_rst() || ready !== exp_ready())
                $display("FAIL rst_hold edge %0d: rst_out=%b ready=%b expected %b %b",
                         e, rst_out, ready, exp_rst(), exp_ready());
            else n_pass++;
            if (e0 == 0 && rst_out[0] === 1'b0) e0 = e;
            if (ready === 1'b1) er = e;
        end
        n_chk++;
        if (e0 != 20 || er != 44)
            $display("FAIL rst_hold_timing: ch0 %0d ready %0d expected 20 44", e0, er);
        else n_pass++;
    endtask

    task automatic test_stagger0();
        rst2 = 1'b1;
        pll2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        pll2 = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (e < 5 && (rst_out2 !== 3'b111 || ready2 !== 1'b0))
                $display("FAIL stagger0 edge %0d: rst_out=%b ready=%b expected 111 0", e, rst_out2, ready2);
            else if (e >= 5 && (rst_out2 !== 3'b000 || ready2 !== 1'b1))
                $display("FAIL stagger0 edge %0d: rst_out=%b ready=%b expected 000 1", e, rst_out2, ready2);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        bit dropped = 0;
        step(1'b0, 1'b0);
        for (int e = 1; e <= 60; e++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (rst_out !== exp_rst() || ready !== exp_ready())
                $display("FAIL glitch edge %0d: rst_out=%b ready=%b expected %b %b",
                         e, rst_out, ready, exp_rst(), exp_ready());
            else n_pass++;
            if (ready === 1'b0 && rst_out === 4'b1111) dropped = 1;
        end
        n_chk++;
        if (!dropped || ready !== 1'b1)
            $display("FAIL glitch_reseq: dropped=%0d ready=%b expected 1 1", dropped, ready);
        else n_pass++;
`ifdef RST_SEQ_LOSS_CNT_EN
        for (int k = 0; k < 270; k++) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
            n_chk++;
            if (lock_loss_cnt !== 8'(m_loss))
                $display("FAIL loss_sat iter %0d: lock_loss_cnt=%0d expected %0d", k, lock_loss_cnt, m_loss);
            else n_pass++;
        end
        n_chk++;
        if (lock_loss_cnt !== 8'd255)
            $display("FAIL loss_sat_final: lock_loss_cnt=%0d expected 255", lock_loss_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic p    = 1'b0;
        logic r;
        int   left = 0;
        for (int c = 0; c < 2500; c++) begin
            if (left == 0) begin
                p    = ~p;
                left = p ? int'($urandom_range(1, 70)) : int'($urandom_range(1, 4));
            end
            left--;
            r = ($urandom_range(0, 199) == 0);
            step(r, p);
            n_chk++;
            if (rst_out !== exp_rst() || ready !== exp_ready())
                $display("FAIL random cyc %0d: rst_out=%b ready=%b expected %b %b",
                         c, rst_out, ready, exp_rst(), exp_ready());
            else n_pass++;
`ifdef RST_SEQ_LOSS_CNT_EN
            n_chk++;
            if (lock_loss_cnt !== 8'(m_loss))
                $display("FAIL random_cnt cyc %0d: lock_loss_cnt=%0d expected %0d", c, lock_loss_cnt, m_loss);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_lock_loss_run();
        test_loss_mid_release();
        test_rst_in_hold();
        test_stagger0();
        test_glitch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
